// File: rtl/counter_prog.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : counter_prog
// Purpose : Programmable-modulus event counter with prescaler, start/stop
//           control and three count modes (wrap, one-shot, up/down
//           ping-pong). Configuration is captured when a run is launched,
//           so the modulus can change from one transaction to the next.
// Ports   :
//   clk           in   1          clock, all logic on rising edge
//   reset         in   1          synchronous active-high reset
//   cfg_limit     in   CNT_WIDTH  terminal value, count range 0..cfg_limit
//   cfg_prescale  in   PRE_WIDTH  one step per (cfg_prescale+1) flagged cycles
//   cfg_mode      in   2          00 wrap, 01 one-shot, 10 ping-pong, 11 wrap
//   start         in   1          launch a run (honoured in IDLE/DONE)
//   stop          in   1          abort, back to IDLE (wins over start)
//   cnt_add_flag  in   1          cycle qualifier for the prescaler
//   cnt           out  CNT_WIDTH  current count (registered)
//   cnt_end       out  1          RUN and cnt at current-direction endpoint
//   tc_pulse      out  1          1-cycle pulse after an endpoint step
//   busy          out  1          high in RUN
//   done          out  1          high in DONE (one-shot finished)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module counter_prog #(
  parameter int CNT_WIDTH = 8,
  parameter int PRE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_WIDTH-1:0] cfg_limit,
  input  logic [PRE_WIDTH-1:0] cfg_prescale,
  input  logic [1:0]           cfg_mode,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 cnt_add_flag,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 cnt_end,
  output logic                 tc_pulse,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] c_mode_oneshot  = 2'b01;
  localparam logic [1:0] c_mode_pingpong = 2'b10;

  localparam logic [CNT_WIDTH-1:0] c_cnt_zero = '0;
  localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);
  localparam logic [PRE_WIDTH-1:0] c_pre_zero = '0;
  localparam logic [PRE_WIDTH-1:0] c_pre_one  = PRE_WIDTH'(1);

  state_t               state_q,   state_d;
  logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
  logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;   // running prescaler
  logic                 dir_dn_q,  dir_dn_d;    // 1 = counting down (ping-pong)
  logic                 tc_q,      tc_d;
  logic [CNT_WIDTH-1:0] lim_q,     lim_d;       // latched terminal value
  logic [PRE_WIDTH-1:0] pre_q,     pre_d;       // latched prescale value
  logic [1:0]           mode_q,    mode_d;      // latched mode

  logic w_is_oneshot;
  logic w_is_pingpong;
  logic w_at_end;
  logic w_step;

  assign w_is_oneshot  = (mode_q == c_mode_oneshot);
  assign w_is_pingpong = (mode_q == c_mode_pingpong);

  // Endpoint in the current direction. Only ping-pong ever counts down, so
  // the low endpoint applies only there.
  assign w_at_end = (w_is_pingpong && dir_dn_q) ? (cnt_q == c_cnt_zero)
                                                : (cnt_q == lim_q);

  // A count step happens when the prescaler has seen pre_q+1 flagged cycles.
  assign w_step = (state_q == ST_RUN) && cnt_add_flag && (pre_cnt_q == pre_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pre_cnt_d = pre_cnt_q;
    dir_dn_d  = dir_dn_q;
    tc_d      = 1'b0;
    lim_d     = lim_q;
    pre_d     = pre_q;
    mode_d    = mode_q;

    if (stop) begin
      state_d   = ST_IDLE;
      cnt_d     = c_cnt_zero;
      pre_cnt_d = c_pre_zero;
      dir_dn_d  = 1'b0;
    end else if (start && (state_q != ST_RUN)) begin
      lim_d     = cfg_limit;
      pre_d     = cfg_prescale;
      mode_d    = cfg_mode;
      state_d   = ST_RUN;
      cnt_d     = c_cnt_zero;
      pre_cnt_d = c_pre_zero;
      dir_dn_d  = 1'b0;
    end else if ((state_q == ST_RUN) && cnt_add_flag) begin
      if (!w_step) begin
        pre_cnt_d = pre_cnt_q + c_pre_one;
      end else begin
        pre_cnt_d = c_pre_zero;
        if (lim_q == c_cnt_zero) begin
          // Degenerate range: every step lands on the endpoint.
          cnt_d = c_cnt_zero;
          tc_d  = 1'b1;
          if (w_is_oneshot) begin
            state_d = ST_DONE;
          end
        end else if (w_is_pingpong) begin
          if (!dir_dn_q) begin
            if (cnt_q == lim_q) begin
              dir_dn_d = 1'b1;
              cnt_d    = lim_q - c_cnt_one;
              tc_d     = 1'b1;
            end else begin
              cnt_d = cnt_q + c_cnt_one;
            end
          end else begin
            if (cnt_q == c_cnt_zero) begin
              dir_dn_d = 1'b0;
              cnt_d    = c_cnt_one;
              tc_d     = 1'b1;
            end else begin
              cnt_d = cnt_q - c_cnt_one;
            end
          end
        end else begin
          // Wrap and one-shot; the endpoint test comes first so that an
          // all-ones limit never computes cnt+1 at the top.
          if (cnt_q == lim_q) begin
            tc_d = 1'b1;
            if (w_is_oneshot) begin
              state_d = ST_DONE;
            end else begin
              cnt_d = c_cnt_zero;
            end
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= c_cnt_zero;
      pre_cnt_q <= c_pre_zero;
      dir_dn_q  <= 1'b0;
      tc_q      <= 1'b0;
      lim_q     <= c_cnt_zero;
      pre_q     <= c_pre_zero;
      mode_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_cnt_q <= pre_cnt_d;
      dir_dn_q  <= dir_dn_d;
      tc_q      <= tc_d;
      lim_q     <= lim_d;
      pre_q     <= pre_d;
      mode_q    <= mode_d;
    end
  end

  assign cnt      = cnt_q;
  assign cnt_end  = (state_q == ST_RUN) && w_at_end;
  assign tc_pulse = tc_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_counter_prog.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_counter_prog
// Purpose : Self-checking bench for counter_prog. A position-based reference
//           model tracks each run; directed scenarios are followed by a long
//           randomized phase and a short narrow-width wrap check.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_counter_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [7:0] cfg_limit = '0;
  logic [3:0] cfg_prescale = '0;
  logic [1:0] cfg_mode = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       cnt_add_flag = 1'b0;
  logic [7:0] cnt;
  logic       cnt_end, tc_pulse, busy, done;

  // narrow instance for the 4-bit all-ones limit
  logic [3:0] cfg_limit4 = '0;
  logic       start4 = 1'b0;
  logic [3:0] cnt4;
  logic       cnt_end4, tc_pulse4, busy4, done4;

  counter_prog #(.CNT_WIDTH(8), .PRE_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .cfg_limit(cfg_limit), .cfg_prescale(cfg_prescale),
    .cfg_mode(cfg_mode), .start(start), .stop(stop), .cnt_add_flag(cnt_add_flag),
    .cnt(cnt), .cnt_end(cnt_end), .tc_pulse(tc_pulse), .busy(busy), .done(done)
  );

  counter_prog #(.CNT_WIDTH(4), .PRE_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .cfg_limit(cfg_limit4), .cfg_prescale(4'd0),
    .cfg_mode(2'b00), .start(start4), .stop(1'b0), .cnt_add_flag(1'b1),
    .cnt(cnt4), .cnt_end(cnt_end4), .tc_pulse(tc_pulse4), .busy(busy4), .done(done4)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A run is described by a step position. Wrap/one-shot: pos 0..L is the
  // count itself. Ping-pong: pos 0..2L walks up then down, pos 2L is "at 0
  // heading up next", and the step after it lands on pos 1.
  int m_st   = 0;   // 0 idle, 1 run, 2 done
  int m_pos  = 0;
  int m_pc   = 0;   // flagged cycles seen since last step
  int m_lim  = 0;
  int m_psc  = 0;
  int m_mode = 0;   // 0 wrap, 1 one-shot, 2 ping-pong
  int m_tc   = 0;

  function automatic int m_cnt();
    if (m_st == 2) return m_lim;
    if (m_mode == 2 && m_pos > m_lim) return 2 * m_lim - m_pos;
    return m_pos;
  endfunction

  function automatic int m_end();
    if (m_st != 1) return 0;
    if (m_lim == 0) return 1;
    if (m_mode == 2) return (m_pos == m_lim || m_pos == 2 * m_lim) ? 1 : 0;
    return (m_pos == m_lim) ? 1 : 0;
  endfunction

  task automatic m_advance();
    if (m_lim == 0) begin
      m_tc = 1;
      if (m_mode == 1) m_st = 2;
    end else if (m_mode == 2) begin
      if (m_pos == m_lim || m_pos == 2 * m_lim) m_tc = 1;
      m_pos = (m_pos == 2 * m_lim) ? 1 : m_pos + 1;
    end else if (m_pos == m_lim) begin
      m_tc = 1;
      if (m_mode == 1) m_st = 2;
      else m_pos = 0;
    end else begin
      m_pos = m_pos + 1;
    end
  endtask

  task automatic m_clock();
    m_tc = 0;
    if (reset) begin
      m_st = 0; m_pos = 0; m_pc = 0; m_lim = 0; m_psc = 0; m_mode = 0;
    end else if (stop) begin
      m_st = 0; m_pos = 0; m_pc = 0;
    end else if (start && m_st != 1) begin
      m_lim  = int'(cfg_limit);
      m_psc  = int'(cfg_prescale);
      m_mode = (cfg_mode == 2'b11) ? 0 : int'(cfg_mode);
      m_st = 1; m_pos = 0; m_pc = 0;
    end else if (m_st == 1 && cnt_add_flag) begin
      if (m_pc == m_psc) begin
        m_pc = 0;
        m_advance();
      end else begin
        m_pc = m_pc + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    #1;
    chk("cnt",      int'(cnt),      m_cnt());
    chk("cnt_end",  int'(cnt_end),  m_end());
    chk("tc_pulse", int'(tc_pulse), m_tc);
    chk("busy",     int'(busy),     (m_st == 1) ? 1 : 0);
    chk("done",     int'(done),     (m_st == 2) ? 1 : 0);
  endtask

  task automatic launch(input int lim, input int psc, input int mode);
    cfg_limit = 8'(lim); cfg_prescale = 4'(psc); cfg_mode = 2'(mode);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();

    // wrap, limit 3, prescale 0
    cnt_add_flag = 1'b1;
    launch(3, 0, 0);
    repeat (9) tick();
    stop = 1'b1; tick(); stop = 1'b0;

    // wrap, limit 2, prescale 2, qualifier toggling
    launch(2, 2, 0);
    for (int i = 0; i < 24; i++) begin
      cnt_add_flag = ~cnt_add_flag;
      tick();
    end
    cnt_add_flag = 1'b1;

    // one-shot limit 4, then restart from DONE with limit 1
    launch(4, 0, 1);
    repeat (8) tick();
    launch(1, 0, 1);
    repeat (4) tick();

    // ping-pong limit 3, then limit 0
    launch(3, 0, 2);
    repeat (12) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    launch(0, 0, 2);
    repeat (4) tick();
    stop = 1'b1; tick(); stop = 1'b0;

    // control: start+stop together, cfg change in RUN, stop, reset mid-run
    cfg_limit = 8'd5; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    launch(5, 1, 0);
    repeat (3) tick();
    cfg_limit = 8'd1; cfg_prescale = 4'd0; cfg_mode = 2'b10;
    start = 1'b1;
    repeat (6) tick();
    start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    launch(2, 0, 0);
    repeat (2) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    tick();

    // 8-bit all-ones limit in wrap
    launch(255, 0, 3);
    repeat (260) tick();
    stop = 1'b1; tick(); stop = 1'b0;

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 399) == 0);
      stop         = ($urandom_range(0, 39) == 0);
      start        = ($urandom_range(0, 9) == 0);
      cnt_add_flag = ($urandom_range(0, 3) != 0);
      cfg_mode     = 2'($urandom_range(0, 3));
      cfg_prescale = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0, 1:    cfg_limit = 8'($urandom_range(0, 5));
        2:       cfg_limit = 8'($urandom_range(0, 40));
        default: cfg_limit = 8'($urandom_range(250, 255));
      endcase
      tick();
    end
    reset = 1'b0; stop = 1'b0; start = 1'b0;

    // 4-bit instance: limit 15 wraps cleanly to 0
    reset = 1'b1; tick(); reset = 1'b0;
    cfg_limit4 = 4'd15; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("w4_cnt_start", int'(cnt4), 0);
    chk("w4_busy", int'(busy4), 1);
    for (int i = 1; i <= 34; i++) begin
      tick();
      chk("w4_cnt",     int'(cnt4),      i % 16);
      chk("w4_cnt_end", int'(cnt_end4),  (i % 16 == 15) ? 1 : 0);
      chk("w4_tc",      int'(tc_pulse4), (i % 16 == 0) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
